// File: rtl/imem_arbiter.sv
// imem_arbiter
// Shares one single-ported synchronous instruction memory between the IF-stage
// fetch path and the program loader/debug port. At most one request is granted
// per cycle; the winner drives the memory port combinationally. The one-cycle
// read data is routed back to whichever requester issued the read.
//
// Handshake: a transfer happens on the rising edge where req && gnt. Grants are
// combinational from the current requests and registered state. Requesters hold
// address/data stable until granted. Read data returns (rvalid) one cycle after
// the granting edge.
//
// Ports
//   clk, reset          clock, asynchronous active-high reset
//   if_req/if_addr      fetch read request and word address
//   if_kill             fetch redirect, drops the in-flight fetch response
//   if_gnt/if_rvalid/if_rdata   fetch grant and read response
//   ld_req/ld_we/ld_lock/ld_addr/ld_wdata  loader request, write, lock, addr, data
//   ld_gnt/ld_rvalid/ld_rdata   loader grant and read response
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata  memory port
//   dbg_state/dbg_wait_cnt      arbiter state (0 = ARB, 1 = EXCL) and starvation count
module imem_arbiter #(
  parameter int ADDR_W   = 10,  // word-address width of the instruction memory
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4    // 1..15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_kill,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic              ld_lock,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_gnt,
  output logic              ld_rvalid,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [0:0]        dbg_state,
  output logic [3:0]        dbg_wait_cnt
);

  typedef enum logic [0:0] {ST_ARB = 1'b0, ST_EXCL = 1'b1} state_t;

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_wait_cnt;
  logic [3:0] w_wait_cnt_nxt;
  logic       r_resp_valid;
  logic       r_resp_owner;  // 0 = fetch, 1 = loader
  logic       w_if_gnt;
  logic       w_ld_gnt;
  logic       w_rd_gnt;

  // Arbitration and next state. Grants are forced low while reset is held so
  // the memory port stays idle regardless of requests.
  always_comb begin
    w_if_gnt    = 1'b0;
    w_ld_gnt    = 1'b0;
    w_state_nxt = r_state;
    if (!reset) begin
      case (r_state)
        ST_ARB: begin
          if ((r_wait_cnt == MAX_WAIT_C) && ld_req) begin
            w_ld_gnt = 1'b1;
          end else if (if_req) begin
            w_if_gnt = 1'b1;
          end else if (ld_req) begin
            w_ld_gnt = 1'b1;
          end
          // Lock only takes hold on a granted loader transfer.
          if (ld_req && w_ld_gnt && ld_lock) begin
            w_state_nxt = ST_EXCL;
          end
        end
        ST_EXCL: begin
          w_ld_gnt = ld_req;
          // A transfer in the release cycle still completes via w_ld_gnt.
          if (!ld_lock) begin
            w_state_nxt = ST_ARB;
          end
        end
        default: w_state_nxt = ST_ARB;
      endcase
    end
  end

  // Starvation counter: counts denied loader cycles in ARB, saturating.
  always_comb begin
    w_wait_cnt_nxt = r_wait_cnt;
    if (w_ld_gnt || !ld_req) begin
      w_wait_cnt_nxt = 4'd0;
    end else if ((r_state == ST_ARB) && (r_wait_cnt < MAX_WAIT_C)) begin
      w_wait_cnt_nxt = r_wait_cnt + 4'd1;
    end
  end

  assign w_rd_gnt = w_if_gnt | (w_ld_gnt & ~ld_we);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_ARB;
      r_wait_cnt   <= 4'd0;
      r_resp_valid <= 1'b0;
      r_resp_owner <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_wait_cnt   <= w_wait_cnt_nxt;
      r_resp_valid <= w_rd_gnt;
      if (w_rd_gnt) begin
        r_resp_owner <= w_ld_gnt;
      end
    end
  end

  assign if_gnt    = w_if_gnt;
  assign ld_gnt    = w_ld_gnt;
  assign mem_en    = w_if_gnt | w_ld_gnt;
  assign mem_we    = w_ld_gnt & ld_we;
  assign mem_addr  = w_if_gnt ? if_addr : (w_ld_gnt ? ld_addr : '0);
  assign mem_wdata = w_ld_gnt ? ld_wdata : '0;

  // Response routing; the reset term keeps outputs quiet while reset is held.
  assign if_rvalid = r_resp_valid & ~r_resp_owner & ~if_kill & ~reset;
  assign ld_rvalid = r_resp_valid & r_resp_owner & ~reset;
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign ld_rdata  = ld_rvalid ? mem_rdata : '0;

  assign dbg_state    = r_state;
  assign dbg_wait_cnt = r_wait_cnt;

endmodule

// File: tb/tb_imem_arbiter.sv
module tb_imem_arbiter;

  localparam int ADDR_W   = 10;
  localparam int DATA_W   = 32;
  localparam int MAX_WAIT = 4;
  localparam int DEPTH    = 1 << ADDR_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic              if_req, if_kill, if_gnt, if_rvalid;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              ld_req, ld_we, ld_lock, ld_gnt, ld_rvalid;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_wdata, ld_rdata;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic [0:0]        dbg_state;
  logic [3:0]        dbg_wait_cnt;

  imem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ld_req(ld_req), .ld_we(ld_we), .ld_lock(ld_lock), .ld_addr(ld_addr),
    .ld_wdata(ld_wdata), .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .dbg_state(dbg_state), .dbg_wait_cnt(dbg_wait_cnt)
  );

  // Synchronous single-port memory; preloaded with addr*4 on the first edge
  // (reset is high then, so the port is idle).
  logic [DATA_W-1:0] ram [DEPTH];
  logic              ram_init = 1'b0;
  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= DATA_W'(i * 4);
      ram_init <= 1'b1;
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  // ---------------- scoreboard ----------------
  logic [DATA_W-1:0] ref_mem [DEPTH];
  logic [DATA_W-1:0] if_exp_q[$];
  logic [DATA_W-1:0] ld_exp_q[$];
  logic if_pend = 1'b0;
  logic ld_pend = 1'b0;
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".if_gnt"},    64'(if_gnt),    64'd0);
    chk({tag, ".ld_gnt"},    64'(ld_gnt),    64'd0);
    chk({tag, ".if_rvalid"}, 64'(if_rvalid), 64'd0);
    chk({tag, ".ld_rvalid"}, 64'(ld_rvalid), 64'd0);
    chk({tag, ".if_rdata"},  64'(if_rdata),  64'd0);
    chk({tag, ".ld_rdata"},  64'(ld_rdata),  64'd0);
    chk({tag, ".mem_en"},    64'(mem_en),    64'd0);
    chk({tag, ".mem_we"},    64'(mem_we),    64'd0);
    chk({tag, ".mem_addr"},  64'(mem_addr),  64'd0);
    chk({tag, ".mem_wdata"}, 64'(mem_wdata), 64'd0);
  endtask

  // ---------------- driver: one clock cycle ----------------
  // Called at a falling edge with inputs already applied. Checks grants, memory
  // port and responses, predicts the next responses, then advances one cycle.
  task automatic cyc(input logic eig, input logic elg, input string tag);
    logic [ADDR_W-1:0] ea;
    logic [DATA_W-1:0] ed;
    logic eirv, elrv;
    #1;
    ea   = eig ? if_addr : (elg ? ld_addr : '0);
    eirv = if_pend & ~if_kill;
    elrv = ld_pend;
    chk({tag, ".if_gnt"},    64'(if_gnt),    64'(eig));
    chk({tag, ".ld_gnt"},    64'(ld_gnt),    64'(elg));
    chk({tag, ".mem_en"},    64'(mem_en),    64'(eig | elg));
    chk({tag, ".mem_we"},    64'(mem_we),    64'(elg & ld_we));
    chk({tag, ".mem_addr"},  64'(mem_addr),  64'(ea));
    chk({tag, ".mem_wdata"}, 64'(mem_wdata), elg ? 64'(ld_wdata) : 64'd0);
    chk({tag, ".if_rvalid"}, 64'(if_rvalid), 64'(eirv));
    chk({tag, ".ld_rvalid"}, 64'(ld_rvalid), 64'(elrv));
    if (if_pend && if_exp_q.size() > 0) begin
      ed = if_exp_q.pop_front();
      if (!if_kill) chk({tag, ".if_rdata"}, 64'(if_rdata), 64'(ed));
    end
    if (!eirv) chk({tag, ".if_rdata0"}, 64'(if_rdata), 64'd0);
    if (ld_pend && ld_exp_q.size() > 0) begin
      ed = ld_exp_q.pop_front();
      chk({tag, ".ld_rdata"}, 64'(ld_rdata), 64'(ed));
    end
    if (!elrv) chk({tag, ".ld_rdata0"}, 64'(ld_rdata), 64'd0);
    if (eig) if_exp_q.push_back(ref_mem[if_addr]);
    if (elg && !ld_we) ld_exp_q.push_back(ref_mem[ld_addr]);
    if (elg && ld_we) ref_mem[ld_addr] = ld_wdata;
    if_pend = eig;
    ld_pend = elg & ~ld_we;
    @(negedge clk);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [DATA_W-1:0] ed;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = DATA_W'(i * 4);
    if_kill = 1'b0; ld_we = 1'b0; ld_lock = 1'b0; ld_wdata = '0;

    // Reset held with both requesters active: everything quiet.
    reset = 1'b1; if_req = 1'b1; ld_req = 1'b1; if_addr = 10'd7; ld_addr = 10'd9;
    @(negedge clk); #1;
    chk_all_zero("reset_hold");
    @(posedge clk); @(negedge clk); #1;
    chk_all_zero("reset_hold2");
    @(negedge clk);
    reset = 1'b0;
    cyc(1'b1, 1'b0, "reset_exit");   // fetch wins with wait_cnt == 0

    // Fetch stream 0,1,2 -> data 0,4,8, back to back.
    ld_req = 1'b0;
    for (int a = 0; a < 3; a++) begin
      if_addr = ADDR_W'(a);
      cyc(1'b1, 1'b0, "fetch_stream");
    end
    for (int k = 0; k < 5; k++) begin
      if_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
      cyc(1'b1, 1'b0, "fetch_rand");
    end
    if_req = 1'b0;
    cyc(1'b0, 1'b0, "fetch_drain");

    // Starvation: fetch for MAX_WAIT cycles, loader on the next one.
    if_req = 1'b1; ld_req = 1'b1; ld_we = 1'b0; ld_addr = 10'd20;
    for (int k = 0; k < MAX_WAIT; k++) begin
      if_addr = ADDR_W'(30 + k);
      cyc(1'b1, 1'b0, "starve_if");
    end
    chk("starve.wait_sat", 64'(dbg_wait_cnt), 64'(MAX_WAIT));
    cyc(1'b0, 1'b1, "starve_ld");
    ld_req = 1'b0; if_addr = 10'd40;
    cyc(1'b1, 1'b0, "starve_resume");
    if_req = 1'b0;
    cyc(1'b0, 1'b0, "starve_drain");

    // Exclusive burst: 8 locked writes, fetch requesting but blocked.
    ld_req = 1'b1; ld_we = 1'b1; ld_lock = 1'b1;
    for (int a = 0; a < 8; a++) begin
      ld_addr  = ADDR_W'(100 + a);
      ld_wdata = DATA_W'($urandom_range(0, 32'h7fff_ffff));
      if (a == 1) begin
        if_req  = 1'b1;
        if_addr = 10'd100;
        chk("burst.state_excl", 64'(dbg_state), 64'd1);
      end
      cyc(1'b0, 1'b1, "burst_wr");
    end
    ld_lock = 1'b0; ld_req = 1'b0; ld_we = 1'b0;
    cyc(1'b0, 1'b0, "burst_unlock");
    chk("burst.state_arb", 64'(dbg_state), 64'd0);
    cyc(1'b1, 1'b0, "burst_post_fetch");   // reads back burst word 100
    if_req = 1'b0; ld_req = 1'b1; ld_addr = 10'd103;
    cyc(1'b0, 1'b1, "burst_ld_readback");
    ld_req = 1'b0;
    cyc(1'b0, 1'b0, "burst_drain");

    // Lock without a grant has no effect.
    if_req = 1'b1; if_addr = 10'd3; ld_req = 1'b1; ld_lock = 1'b1; ld_addr = 10'd4;
    cyc(1'b1, 1'b0, "lock_nogrant");
    chk("lock_nogrant.state", 64'(dbg_state), 64'd0);
    ld_req = 1'b0; ld_lock = 1'b0;
    cyc(1'b1, 1'b0, "lock_nogrant2");
    if_req = 1'b0;
    cyc(1'b0, 1'b0, "lock_drain");

    // Kill: response of N dropped at N+1, new fetch at N+1 returns at N+2.
    if_req = 1'b1; if_addr = 10'd5;
    cyc(1'b1, 1'b0, "kill_n");
    if_kill = 1'b1; if_addr = 10'd6;
    cyc(1'b1, 1'b0, "kill_n1");
    if_kill = 1'b0; if_req = 1'b0;
    cyc(1'b0, 1'b0, "kill_n2");

    // Kill with no fetch pending: loader response unaffected.
    ld_req = 1'b1; ld_we = 1'b0; ld_addr = 10'd50;
    cyc(1'b0, 1'b1, "kill_idle_ld");
    ld_req = 1'b0; if_kill = 1'b1;
    cyc(1'b0, 1'b0, "kill_idle");
    if_kill = 1'b0;

    // Mid-operation reset: loader read granted, reset before its response.
    if_req = 1'b1; ld_req = 1'b1; ld_we = 1'b0; ld_addr = 10'd60;
    if_addr = 10'd70;
    cyc(1'b1, 1'b0, "mid_rst_if0");
    if_addr = 10'd71;
    cyc(1'b1, 1'b0, "mid_rst_if1");
    chk("mid_rst.wait2", 64'(dbg_wait_cnt), 64'd2);
    if_req = 1'b0;
    #1;
    chk("mid_rst.ld_gnt", 64'(ld_gnt), 64'd1);
    chk("mid_rst.if_rvalid", 64'(if_rvalid), 64'd1);
    ed = if_exp_q.pop_front();
    chk("mid_rst.if_rdata", 64'(if_rdata), 64'(ed));
    reset = 1'b1;
    #1;
    chk_all_zero("mid_rst_hold");
    if_exp_q.delete(); ld_exp_q.delete();
    if_pend = 1'b0; ld_pend = 1'b0;
    @(posedge clk); @(negedge clk); #1;
    chk_all_zero("mid_rst_hold2");
    @(negedge clk);
    reset = 1'b0; ld_req = 1'b0;
    chk("mid_rst.state", 64'(dbg_state), 64'd0);
    chk("mid_rst.wait0", 64'(dbg_wait_cnt), 64'd0);
    cyc(1'b0, 1'b0, "mid_rst_after");
    cyc(1'b0, 1'b0, "mid_rst_after2");
    if_req = 1'b1; if_addr = 10'd11;
    cyc(1'b1, 1'b0, "final_fetch");
    if_req = 1'b0;
    cyc(1'b0, 1'b0, "final_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Shares the single-ported synchronous instruction memory between the IF stage fetch path and the program loader/debug port. Each cycle it grants at most one request and drives the memory port from the winner. It routes the one-cycle-latency read data back to the requester that issued it. Fetch has priority, loader starvation is bounded, and the loader can lock the memory for burst programming.

## Interface
- ADDR_W, default WORD_ADDR_WIDTH: word-address width.
- DATA_W, default XLEN (32): data width.
- MAX_WAIT, default 4: number of consecutive denied loader cycles before the loader wins priority. Range 1..15.

- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch read request.
- if_addr  in  ADDR_W  fetch word address.
- if_kill  in  1  fetch redirect; drops the in-flight fetch response.
- if_gnt  out  1  fetch request accepted this cycle.
- if_rvalid  out  1  fetch read data valid.
- if_rdata  out  DATA_W  fetch read data.
- ld_req  in  1  loader request.
- ld_we  in  1  loader write (1) or read (0).
- ld_lock  in  1  loader requests exclusive ownership.
- ld_addr  in  ADDR_W  loader word address.
- ld_wdata  in  DATA_W  loader write data.
- ld_gnt  out  1  loader request accepted this cycle.
- ld_rvalid  out  1  loader read data valid.
- ld_rdata  out  DATA_W  loader read data.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; valid the cycle after a read with mem_en=1, mem_we=0.

## Operation
- **Handshake.** A transfer happens on the clock edge where req && gnt. Grants are combinational from the current requests and registered state. A requester must hold address and data stable until it is granted.
- **Memory port.** The memory port is driven combinationally from the granted requester. mem_en = if_gnt | ld_gnt. mem_we = ld_gnt & ld_we. With no grant, mem_addr and mem_wdata are 0.

**States**
- ARB (normal arbitration):
  - If wait_cnt == MAX_WAIT and ld_req: the loader wins.
  - Otherwise, if if_req: fetch wins.
  - Otherwise, if ld_req: the loader wins.
- EXCL (exclusive loader ownership):
  - if_gnt = 0.
  - ld_gnt = ld_req.
- **Transitions.**
  - ARB→EXCL on the edge where ld_req && ld_gnt && ld_lock.
  - EXCL→ARB on the edge where ld_lock = 0. A loader transfer in that same cycle still completes.

**Starvation counter (wait_cnt, 4 bits)**
- Increments, saturating at MAX_WAIT, on each ARB-state edge with ld_req && !ld_gnt.
- Clears on any ld_gnt or when ld_req = 0.

**Response tracking**
- Registers resp_valid and resp_owner (0 = fetch, 1 = loader).
- resp_valid is set on the edge of any granted read (fetch read, or loader read with ld_we = 0).
- if_rvalid = resp_valid && owner = 0 && !if_kill.
- ld_rvalid = resp_valid && owner = 1.
- rdata outputs pass mem_rdata through when the corresponding rvalid = 1; otherwise they are 0.
- Loader writes produce no response.

**Boundary conditions**
- Both requesters request and wait_cnt < MAX_WAIT: fetch is granted and the counter increments.
- if_kill asserted with no pending fetch response: no effect.
- A new fetch may be granted in the same cycle the previous response is returned, giving back-to-back throughput of 1 per cycle.
- ld_lock asserted without a grant has no effect until the loader is granted.

**Reset (asynchronous)**
- State = ARB, wait_cnt = 0, resp_valid = 0, resp_owner = 0.
- While reset is high, all gnt, rvalid, rdata and mem_* outputs are 0. This holds regardless of requests.
- A reset in the middle of a transfer discards the pending response.

## Timing
- Grant latency is 0 cycles: gnt is combinational in the request cycle.
- Read latency is 1 cycle: rvalid is asserted the cycle after the grant.
- Loader worst-case wait in ARB under continuous fetch is MAX_WAIT cycles; it is granted on the (MAX_WAIT+1)th cycle of requesting.
- Fetch worst-case wait is unbounded while in EXCL.
- Combinational paths: req/addr → gnt/mem_*, mem_rdata → rdata, and if_kill → if_rvalid.

## Test plan
- **Reset.** Assert reset with if_req = ld_req = 1 → all outputs 0. Deassert reset → the first cycle gives if_gnt = 1, mem_addr = if_addr.
- **Fetch stream.** if_req held with addresses 0, 1, 2 and memory returning addr*4 → if_rvalid on cycles 1–3 with rdata 0, 4, 8; ld_rvalid stays 0.
- **Starvation.** MAX_WAIT = 4; if_req and ld_req held, ld_we = 0 → if_gnt for 4 cycles, ld_gnt on the 5th, ld_rvalid on the 6th, then fetch resumes.
- **Exclusive burst.** Loader granted with ld_lock = 1, writes to addresses 0..7, then ld_lock = 0 → if_gnt = 0 throughout the burst. mem_we = 1 for 8 cycles. Fetch is granted the cycle after lock release.
- **Kill.** Fetch granted at cycle N, if_kill = 1 at N+1 → if_rvalid = 0 at N+1. A new fetch granted at N+1 returns normally at N+2.
- **Mid-operation reset.** Loader read granted, reset asserted before the response → ld_rvalid is never asserted. After reset: state = ARB, wait_cnt = 0.
